// File: rtl/ldm_stm_seq_if.sv
// Bus bundle for the LDM/STM block-transfer sequencer: command inputs,
// memory port, register-file ports and PC load.
interface ldm_stm_seq_if;
  logic        start;
  logic        is_load;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [31:0] base;
  logic        up;
  logic        pre;
  logic        wback;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pc_we;
  logic [31:0] pc_wd;

  modport slave (
    input  start, is_load, reglist, rn, base, up, pre, wback,
    input  mem_ack, mem_rdata, rf_rd,
    output busy, done, mem_req, mem_we, mem_addr, mem_wdata,
    output rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );

  modport master (
    output start, is_load, reglist, rn, base, up, pre, wback,
    output mem_ack, mem_rdata, rf_rd,
    input  busy, done, mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list in ascending
// order, one word per acked memory access, with optional base writeback.
module ldm_stm_seq (
  input  logic           clk,
  input  logic           reset,
  ldm_stm_seq_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_load;
  logic [15:0] r_list;
  logic [3:0]  r_rn;
  logic [31:0] r_addr;
  logic [31:0] r_wb_val;
  logic        r_do_wb;

  logic [4:0]  w_cnt;
  logic [31:0] w_span;
  logic [31:0] w_start_addr;
  logic [3:0]  w_idx;
  logic        w_last;
  logic        w_launch;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < 16; i++)
      w_cnt = w_cnt + 5'(bus.reglist[i]);
  end

  assign w_span = {25'd0, w_cnt, 2'b00};

  always_comb begin
    case ({bus.up, bus.pre})
      2'b10:   w_start_addr = bus.base;
      2'b11:   w_start_addr = bus.base + 32'd4;
      2'b00:   w_start_addr = bus.base - w_span + 32'd4;
      default: w_start_addr = bus.base - w_span;
    endcase
  end

  // Pending registers are kept as a shrinking mask; the lowest set bit is
  // always the current transfer, which yields ascending index order.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 16; i > 0; i--)
      if (r_list[i-1]) w_idx = 4'(i - 1);
  end

  assign w_last   = ((r_list & (r_list - 16'd1)) == '0);
  assign w_launch = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.reglist == '0) ? S_DONE : S_XFER;
      S_XFER: if (bus.mem_ack && w_last) w_next = r_do_wb ? S_WB : S_DONE;
      S_WB:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_load <= 1'b0;
      r_list    <= '0;
      r_rn      <= '0;
      r_addr    <= '0;
      r_wb_val  <= '0;
      r_do_wb   <= 1'b0;
    end else if (w_launch) begin
      r_is_load <= bus.is_load;
      r_list    <= bus.reglist;
      r_rn      <= bus.rn;
      r_addr    <= w_start_addr;
      r_wb_val  <= bus.up ? (bus.base + w_span) : (bus.base - w_span);
      // A loaded base register must keep its loaded value.
      r_do_wb   <= bus.wback && !(bus.is_load && bus.reglist[bus.rn]);
    end else if (r_state == S_XFER && bus.mem_ack) begin
      r_list <= r_list & ~(16'd1 << w_idx);
      r_addr <= r_addr + 32'd4;
    end
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rf_ra     = '0;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = '0;
    bus.rf_wd     = '0;
    bus.pc_we     = 1'b0;
    bus.pc_wd     = '0;
    case (r_state)
      S_XFER: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = ~r_is_load;
        bus.mem_addr = r_addr;
        if (!r_is_load) begin
          bus.rf_ra     = w_idx;
          bus.mem_wdata = bus.rf_rd;
        end else if (bus.mem_ack) begin
          if (w_idx == 4'hF) begin
            bus.pc_we = 1'b1;
            bus.pc_wd = bus.mem_rdata;
          end else begin
            bus.rf_we = 1'b1;
            bus.rf_wa = w_idx;
            bus.rf_wd = bus.mem_rdata;
          end
        end
      end
      S_WB: begin
        bus.busy  = 1'b1;
        bus.rf_we = 1'b1;
        bus.rf_wa = r_rn;
        bus.rf_wd = r_wb_val;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: expected memory/writeback/done events are
// queued before each operation and checked as the sequencer produces them.
module tb_ldm_stm_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ldm_stm_seq_if bus();
  ldm_stm_seq dut (.clk(clk), .reset(reset), .bus(bus));

  // Register file reads return a tagged index; memory reads return ~address.
  assign bus.rf_rd     = {28'hC0DE000, bus.rf_ra};
  assign bus.mem_rdata = ~bus.mem_addr;

  localparam int EV_MEM = 0, EV_WB = 1, EV_DONE = 2;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  idx;
    logic [31:0] data;
  } ev_t;

  ev_t q[$];
  int compared = 0;
  int mism = 0;
  int xfer_cnt = 0;
  int stall_at = 0;
  int stall_n = 0;
  int stall_wait = 0;
  int stall_obs = 0;
  bit prev_stall = 0;
  logic [31:0] prev_addr, prev_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] addr, input logic we,
                         input logic [3:0] idx, input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.idx = idx; e.data = data;
    q.push_back(e);
  endtask

  // Memory model: acks every request except for a planned stall window.
  initial bus.mem_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bus.mem_req && (xfer_cnt + 1 == stall_at) && (stall_wait < stall_n)) begin
      bus.mem_ack = 1'b0;
      stall_wait++;
    end else begin
      bus.mem_ack = bus.mem_req;
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (bus.mem_req) begin
      if (prev_stall) begin
        chk("stall_addr_stable", bus.mem_addr, prev_addr);
        chk("stall_wdata_stable", bus.mem_wdata, prev_wdata);
      end
      if (bus.mem_ack) begin
        xfer_cnt++;
        stall_wait = 0;
        prev_stall = 0;
        chk("mem_event_expected", 32'(q.size() > 0 && q[0].kind == EV_MEM), 32'd1);
        if (q.size() > 0 && q[0].kind == EV_MEM) begin
          e = q.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_we", bus.mem_we, e.we);
          chk("busy_xfer", bus.busy, 1);
          if (e.we) begin
            chk("rf_ra", bus.rf_ra, e.idx);
            chk("mem_wdata", bus.mem_wdata, e.data);
            chk("stm_rf_we", bus.rf_we, 0);
          end else if (e.idx == 4'hF) begin
            chk("pc_we", bus.pc_we, 1);
            chk("pc_wd", bus.pc_wd, e.data);
            chk("r15_rf_we", bus.rf_we, 0);
          end else begin
            chk("ldm_rf_we", bus.rf_we, 1);
            chk("ldm_rf_wa", bus.rf_wa, e.idx);
            chk("ldm_rf_wd", bus.rf_wd, e.data);
            chk("ldm_pc_we", bus.pc_we, 0);
          end
        end
      end else begin
        chk("stall_rf_we", bus.rf_we, 0);
        chk("stall_pc_we", bus.pc_we, 0);
        prev_stall = 1;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
        stall_obs++;
      end
    end else if (bus.rf_we || bus.pc_we) begin
      chk("wb_event_expected", 32'(q.size() > 0 && q[0].kind == EV_WB), 32'd1);
      if (q.size() > 0 && q[0].kind == EV_WB) begin
        e = q.pop_front();
        chk("wb_rf_wa", bus.rf_wa, e.idx);
        chk("wb_rf_wd", bus.rf_wd, e.data);
        chk("wb_busy", bus.busy, 1);
        chk("wb_pc_we", bus.pc_we, 0);
      end
    end
    if (bus.done) begin
      chk("done_event_expected", 32'(q.size() > 0 && q[0].kind == EV_DONE), 32'd1);
      if (q.size() > 0 && q[0].kind == EV_DONE) begin
        e = q.pop_front();
        chk("done_busy", bus.busy, 0);
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_rf_we"}, bus.rf_we, 0);
    chk({tag, "_pc_we"}, bus.pc_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rf_ra"}, bus.rf_ra, 0);
    chk({tag, "_rf_wa"}, bus.rf_wa, 0);
    chk({tag, "_rf_wd"}, bus.rf_wd, 0);
    chk({tag, "_pc_wd"}, bus.pc_wd, 0);
  endtask

  task automatic drive(input bit ld, input logic [15:0] rl, input logic [3:0] rn,
                       input logic [31:0] base, input bit up, input bit pre, input bit wb);
    bus.is_load = ld; bus.reglist = rl; bus.rn = rn; bus.base = base;
    bus.up = up; bus.pre = pre; bus.wback = wb;
  endtask

  // Launches one operation, scrambles inputs (and re-pulses start) while it
  // runs, then checks latency, the one-cycle done pulse and an empty queue.
  task automatic run(input string tag, input bit ld, input logic [15:0] rl,
                     input logic [3:0] rn, input logic [31:0] base,
                     input bit up, input bit pre, input bit wb, input int exp_lat);
    int lat;
    @(posedge clk); #2;
    drive(ld, rl, rn, base, up, pre, wb);
    xfer_cnt = 0; stall_wait = 0; stall_obs = 0; prev_stall = 0;
    bus.start = 1'b1;
    @(posedge clk); #2;
    drive(~ld, ~rl, ~rn, 32'hDEAD_BEEF, ~up, ~pre, ~wb);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (lat >= 2 || bus.done) bus.start = 1'b0;
      if (bus.done) break;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_timeout"}, 32'(lat < 200), 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_queue_drained"}, q.size(), 0);
  endtask

  task automatic model_push(input bit ld, input logic [15:0] rl, input logic [3:0] rn,
                            input logic [31:0] base, input bit up, input bit pre,
                            input bit wb, output int exp_lat);
    int n;
    logic [31:0] a;
    bit do_wb;
    n = $countones(rl);
    if (up) a = pre ? base + 32'd4 : base;
    else    a = pre ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        push_ev(EV_MEM, a, !ld, 4'(i), ld ? ~a : {28'hC0DE000, 4'(i)});
        a = a + 32'd4;
      end
    end
    do_wb = (rl != 0) && wb && !(ld && rl[rn]);
    if (do_wb) push_ev(EV_WB, 0, 0, rn, up ? base + 32'(4 * n) : base - 32'(4 * n));
    push_ev(EV_DONE, 0, 0, 0, 0);
    exp_lat = n + int'(do_wb) + 1;
  endtask

  initial begin
    int lat;
    bus.start = 1'b0;
    drive(0, 16'h0000, 4'h0, 32'h0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #2;
    reset = 1'b0;

    // STM r1,r3 ascending, base writeback.
    push_ev(EV_MEM, 32'h100, 1, 4'd1, 32'hC0DE0001);
    push_ev(EV_MEM, 32'h104, 1, 4'd3, 32'hC0DE0003);
    push_ev(EV_WB, 0, 0, 4'd0, 32'h108);
    push_ev(EV_DONE, 0, 0, 0, 0);
    run("stm_r1r3", 0, 16'h000A, 4'd0, 32'h100, 1, 0, 1, 4);

    // LDM r2,r4,r5 decrement-before.
    push_ev(EV_MEM, 32'h1F4, 0, 4'd2, 32'hFFFF_FE0B);
    push_ev(EV_MEM, 32'h1F8, 0, 4'd4, 32'hFFFF_FE07);
    push_ev(EV_MEM, 32'h1FC, 0, 4'd5, 32'hFFFF_FE03);
    push_ev(EV_WB, 0, 0, 4'd6, 32'h1F4);
    push_ev(EV_DONE, 0, 0, 0, 0);
    run("ldm_r2r4r5", 1, 16'h0034, 4'd6, 32'h200, 0, 1, 1, 5);

    // Three-cycle stall on the second transfer.
    stall_at = 2; stall_n = 3;
    push_ev(EV_MEM, 32'h304, 1, 4'd1, 32'hC0DE0001);
    push_ev(EV_MEM, 32'h308, 1, 4'd2, 32'hC0DE0002);
    push_ev(EV_MEM, 32'h30C, 1, 4'd3, 32'hC0DE0003);
    push_ev(EV_DONE, 0, 0, 0, 0);
    run("stm_stall", 0, 16'h000E, 4'd9, 32'h300, 1, 1, 0, 7);
    chk("stall_cycles_seen", stall_obs, 3);
    stall_at = 0; stall_n = 0;

    // Empty register list.
    push_ev(EV_DONE, 0, 0, 0, 0);
    run("empty_list", 0, 16'h0000, 4'd2, 32'h800, 1, 0, 1, 1);

    // LDM r0,r15 with base in list: PC load, writeback suppressed.
    push_ev(EV_MEM, 32'h40, 0, 4'd0, 32'hFFFF_FFBF);
    push_ev(EV_MEM, 32'h44, 0, 4'd15, 32'hFFFF_FFBB);
    push_ev(EV_DONE, 0, 0, 0, 0);
    run("ldm_r0_pc", 1, 16'h8001, 4'd0, 32'h40, 1, 0, 1, 3);

    // U0P0 wrap-around below zero, full list.
    model_push(0, 16'hFFFF, 4'd13, 32'h0000_0010, 0, 0, 1, lat);
    run("stm_wrap_full", 0, 16'hFFFF, 4'd13, 32'h0000_0010, 0, 0, 1, lat);

    for (int k = 0; k < 3; k++) begin
      logic [15:0] rl;
      logic [3:0]  rn;
      logic [31:0] base;
      bit ld, up, pre, wb;
      rl = 16'($urandom_range(1, 16'hFFFF));
      rn = 4'($urandom);
      base = {$urandom} & 32'hFFFF_FFFC;
      ld = 1'($urandom); up = 1'($urandom); pre = 1'($urandom); wb = 1'($urandom);
      model_push(ld, rl, rn, base, up, pre, wb, lat);
      run("random_op", ld, rl, rn, base, up, pre, wb, lat);
    end

    // Reset during the second XFER cycle of a four-register STM.
    push_ev(EV_MEM, 32'h500, 1, 4'd4, 32'hC0DE0004);
    push_ev(EV_MEM, 32'h504, 1, 4'd5, 32'hC0DE0005);
    @(posedge clk); #2;
    drive(0, 16'h00F0, 4'd1, 32'h500, 1, 0, 1);
    xfer_cnt = 0; prev_stall = 0;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle("after_mid_reset");
    end
    chk("mid_reset_queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
